// File: rtl/vga_dac_pkg.sv
// Shared VGA timing defaults, pattern mode encoding and colour bar table.
package vga_dac_pkg;

  // Default 640x480 @ 60 Hz timing (25.175 MHz pixel clock)
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Counter width, wide enough for any practical line or frame length
  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    MODE_BLACK = 2'b00,
    MODE_BARS  = 2'b01,
    MODE_RAMP  = 2'b10,
    MODE_SOLID = 2'b11
  } vga_mode_e;

  // Colour bars left to right as {R,G,B}: white, yellow, cyan, green,
  // magenta, red, blue, black
  localparam logic [23:0] BAR_TABLE [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with sync and blanking decode.
// Decoded terms are combinational from the current counter values; the
// parent registers them so every output shares one cycle of latency.
module vga_timing
  import vga_dac_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             hblank,
  output logic             vblank,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             frame_origin,
  output logic             frame_last
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] H_BLANK_AT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_BLANK_AT = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;

  // Next raster position: hc wraps every line, vc advances only on hc wrap
  always_comb begin
    hc_d = hc_q + CNT_W'(1);
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      if (vc_q == V_LAST) vc_d = '0;
      else                vc_d = vc_q + CNT_W'(1);
    end
  end

  // Raster position registers, cleared straight back to the frame origin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // Sync, blank and frame-boundary decode of the current position
  always_comb begin
    hc           = hc_q;
    vc           = vc_q;
    hblank       = (hc_q >= H_BLANK_AT);
    vblank       = (vc_q >= V_BLANK_AT);
    hsync_n      = !((hc_q >= HS_FIRST) && (hc_q <= HS_LAST));
    vsync_n      = !((vc_q >= VS_FIRST) && (vc_q <= VS_LAST));
    frame_origin = (hc_q == '0) && (vc_q == '0);
    frame_last   = (hc_q == H_LAST) && (vc_q == V_LAST);
  end

endmodule

// File: rtl/vga_dac_sequencer.sv
// Test-pattern generator feeding three 8-bit R2R DACs. Mode and solid colour
// are sampled once per frame so a pattern never tears mid-frame.
module vga_dac_sequencer
  import vga_dac_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic [7:0]  dr,
  output logic [7:0]  dg,
  output logic [7:0]  db,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic        frame_start
);

  // Bar width and ramp band edges are constants, so the bar index and band
  // come from plain comparisons rather than a divider
  localparam int               BAR_W = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] BAND1 = CNT_W'(V_ACTIVE / 3);
  localparam logic [CNT_W-1:0] BAND2 = CNT_W'((2 * V_ACTIVE) / 3);

  logic [CNT_W-1:0] hc, vc;
  logic             t_hblank, t_vblank, t_hsync_n, t_vsync_n;
  logic             t_origin, t_last;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .hc           (hc),
    .vc           (vc),
    .hblank       (t_hblank),
    .vblank       (t_vblank),
    .hsync_n      (t_hsync_n),
    .vsync_n      (t_vsync_n),
    .frame_origin (t_origin),
    .frame_last   (t_last)
  );

  vga_mode_e   mode_q, mode_d;
  logic [23:0] rgb_q, rgb_d;
  logic [23:0] pix_q, pix_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblank_q, hblank_d;
  logic        vblank_q, vblank_d;
  logic        frame_start_q, frame_start_d;

  logic [2:0]  bar_idx;
  logic [23:0] ramp_rgb;
  logic [23:0] pattern_rgb;

  // Sample pattern settings only on the very last pixel of the frame
  always_comb begin
    mode_d = mode_q;
    rgb_d  = rgb_q;
    if (t_last) begin
      mode_d = vga_mode_e'(mode);
      rgb_d  = solid_rgb;
    end
  end

  // Pattern generation and blanking for the current raster position
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (hc >= CNT_W'(k * BAR_W)) bar_idx = 3'(k);
    end

    if (vc < BAND1)      ramp_rgb = {hc[7:0], 16'h0000};
    else if (vc < BAND2) ramp_rgb = {8'h00, hc[7:0], 8'h00};
    else                 ramp_rgb = {16'h0000, hc[7:0]};

    case (mode_q)
      MODE_BARS:  pattern_rgb = BAR_TABLE[bar_idx];
      MODE_RAMP:  pattern_rgb = ramp_rgb;
      MODE_SOLID: pattern_rgb = rgb_q;
      default:    pattern_rgb = '0;
    endcase

    pix_d         = (t_hblank || t_vblank) ? 24'h000000 : pattern_rgb;
    hsync_d       = t_hsync_n;
    vsync_d       = t_vsync_n;
    hblank_d      = t_hblank;
    vblank_d      = t_vblank;
    frame_start_d = t_origin;
  end

  // Output and settings registers; reset drives the idle, fully blanked state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q        <= MODE_BLACK;
      rgb_q         <= '0;
      pix_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      rgb_q         <= rgb_d;
      pix_q         <= pix_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign dr          = pix_q[23:16];
  assign dg          = pix_q[15:8];
  assign db          = pix_q[7:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_dac_sequencer.md
VGA_DAC_SEQUENCER -- requirements
Module: vga_dac_sequencer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC and H_BP, defaults 16, 96 and 48: horizontal front porch, sync and back porch, in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC and V_BP, defaults 10, 2 and 33: vertical front porch, sync and back porch, in lines.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  pixel clock; the block has one clock.
- rst  in  1  reset; asynchronous and active-high.
- mode  in  2  pattern select: 00 black, 01 colour bars, 10 ramp, 11 solid.
- solid_rgb  in  24  solid colour; [23:16] R, [15:8] G, [7:0] B.
- dr, dg, db  out  8 each  DAC codes for the red, green and blue R2R DACs.
- hsync, vsync  out  1 each  sync outputs, active-low.
- hblank, vblank  out  1 each  blanking flags, active-high.
- frame_start  out  1  one-cycle pulse on the first active pixel of a frame.

Function
REQ-006 SHALL count hc from 0 to HT-1, where HT = sum of the H parameters (800); hc wraps to 0.
REQ-007 SHALL count vc from 0 to VT-1, where VT = sum of the V parameters (525); vc increments only when hc wraps, and wraps to 0 after VT-1.
REQ-008 SHALL register every output, so that outputs in cycle t reflect (hc, vc) of cycle t-1, a latency of 1 clock.
REQ-009 SHALL assert hblank when hc >= H_ACTIVE, and vblank when vc >= V_ACTIVE.
REQ-010 SHALL drive hsync low for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
REQ-011 SHALL drive vsync low for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491).
REQ-012 SHALL force dr, dg and db to 0 whenever hblank or vblank is asserted, regardless of mode.
REQ-013 SHALL latch mode and solid_rgb into mode_q and rgb_q only in the cycle where hc=HT-1 and vc=VT-1; mid-frame input changes SHALL be ignored until the next frame.
REQ-014 SHALL, in mode_q 00, output 0 on all three DACs.
REQ-015 SHALL, in mode_q 01, output 8 vertical bars, bar index = hc / (H_ACTIVE/8) (80 px each), in order white, yellow, cyan, green, magenta, red, blue, black; full colour code 255, absent channel 0.
REQ-016 SHALL, in mode_q 10, divide the active lines into three bands: red for vc 0..159, green for 160..319, blue for 320..479.
REQ-017 SHALL, in mode_q 10, drive the band's channel with hc[7:0] (wrapping every 256 px) and drive the other two channels with 0.
REQ-018 SHALL, in mode_q 11, output rgb_q unchanged on dr/dg/db during active video.
REQ-019 SHALL pulse frame_start for exactly one cycle, coincident with the outputs for hc=0, vc=0.
REQ-020 SHALL implement all division by compare or constant decode only; no runtime divider.

Reset
REQ-021 SHALL, while rst is high, asynchronously clear hc, vc, mode_q and rgb_q to 0.
REQ-022 SHALL, while rst is high, set dr, dg, db and frame_start to 0, hsync and vsync to 1, and hblank and vblank to 1.
REQ-023 SHALL, on the first clock after rst deasserts, register outputs for hc=0, vc=0: hblank=0, vblank=0, frame_start=1.
REQ-024 SHALL, when rst is asserted mid-frame, abandon the frame immediately with no partial sync pulse extension.

Structure
REQ-025 SHALL place the timing defaults, the mode encoding (MODE_BLACK, MODE_BARS, MODE_RAMP, MODE_SOLID) and the 8-entry bar colour table in shared package vga_dac_pkg.
REQ-026 SHALL contain one sub-module, vga_timing, that owns the hc/vc counters and produces the sync and blank terms; pattern selection and output registers stay in vga_dac_sequencer.

Verification
REQ-027 SHALL check: reset release, then 800x525 clocks -> exactly one frame_start at cycle 1 and the next at cycle 420001; hsync low for 96 clocks per line; vsync low for 1600 clocks per frame.
REQ-028 SHALL check: mode=01 latched -> at hc=85 (output cycle hc+1) dr=255, dg=255, db=0 (yellow); at hc=639 all 0 (black); at hc=640 all 0 (blanked).
REQ-029 SHALL check: mode=10, vc=200, hc=300 -> dr=0, dg=44, db=0; vc=400, hc=255 -> db=255; hc=256 -> db=0.
REQ-030 SHALL check: mode changed from 01 to 11 with solid_rgb=0x123456 mid-frame at vc=100 -> bars persist to frame end; next frame active pixels show dr=0x12, dg=0x34, db=0x56.
REQ-031 SHALL check: rst pulsed at vc=300, hc=700 -> outputs take reset values asynchronously; after release, counting restarts at 0,0 and frame_start pulses on the next clock.
